// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC frame sequencer: FSM states, default
// sizes, serial-engine control words, sentinel sample and the set-bit search.
package adc_pkg;

   localparam int NUM_CH_DEF = 4;
   localparam int DATA_W_DEF = 11;
   localparam int MASK_MAX   = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_PRESENT
   } seq_state_t;

   // Serial engine control words, element k belongs to channel k.
   localparam logic [NUM_CH_DEF-1:0][15:0] CTRL_WORD = {16'h6280, 16'h6080, 16'h6680, 16'h6480};

   localparam logic [DATA_W_DEF-1:0] SAMPLE_MIN = {1'b1, {(DATA_W_DEF-1){1'b0}}};

   // Index of the lowest set bit at or above 'from', or -1 when there is none.
   function automatic int next_set_bit(input logic [MASK_MAX-1:0] mask, input int from);
      int found;
      found = -1;
      for (int i = MASK_MAX - 1; i >= 0; i--) begin
         if (i >= from && mask[i]) found = i;
      end
      return found;
   endfunction

endpackage

// File: rtl/adc_rate_div.sv
// Sample-rate divider: counts 0..RATE_DIV-1 while enabled and flags the last count.
module adc_rate_div #(
   parameter int RATE_DIV = 1250
) (
   input  logic clk_clk,
   input  logic reset_n,
   input  logic en,
   output logic tick
);

   localparam int CNT_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;

   logic [CNT_W-1:0] div_cnt;

   always_ff @(posedge clk_clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= '0;
      end else if (!en || tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   assign tick = (div_cnt == CNT_W'(RATE_DIV - 1));

endmodule

// File: rtl/adc_frame_sequencer.sv
// Walks the ADC engine through every enabled channel on each sample tick and
// presents the collected frame. Define ADC_SEQ_TIMEOUT_EN for the conversion watchdog.
module adc_frame_sequencer
   import adc_pkg::*;
#(
   parameter int NUM_CH   = NUM_CH_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int RATE_DIV = 1250,
   parameter int TIMEOUT  = 64
) (
   input  logic                       clk_clk,
   input  logic                       reset_n,
   input  logic                       en,
   input  logic [NUM_CH-1:0]          ch_mask,
   input  logic                       clr_flags,
   output logic                       conv_req,
   output logic [$clog2(NUM_CH)-1:0]  conv_ch,
   input  logic                       conv_done,
   input  logic [DATA_W-1:0]          conv_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NUM_CH*DATA_W-1:0]   out_data,
   output logic [NUM_CH-1:0]          out_mask,
   output logic                       busy,
   output logic                       overrun,
   output logic                       timeout,
   output logic [15:0]                frame_cnt
);

   localparam int CH_W = $clog2(NUM_CH);
   localparam logic [DATA_W-1:0] SAMPLE_MIN_W = {1'b1, {(DATA_W-1){1'b0}}};

   seq_state_t               state, state_nx;
   logic [CH_W-1:0]          ch, ch_nx;
   logic [NUM_CH-1:0]        mask_q;
   logic [NUM_CH*DATA_W-1:0] slots;
   logic                     tick;
   logic                     load_frame;
   logic                     store_data;
   logic                     store_min;
   logic                     accept;
   logic                     expired;
   int                       nxt;

   adc_rate_div #(
      .RATE_DIV (RATE_DIV)
   ) u_rate_div (
      .clk_clk (clk_clk),
      .reset_n (reset_n),
      .en      (en),
      .tick    (tick)
   );

`ifdef ADC_SEQ_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   logic [WAIT_W-1:0] wait_cnt;

   always_ff @(posedge clk_clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt <= '0;
      end else if (state == ST_WAIT && state_nx == ST_WAIT) begin
         wait_cnt <= wait_cnt + 1'b1;
      end else begin
         wait_cnt <= '0;
      end
   end

   assign expired = (state == ST_WAIT) && (wait_cnt == WAIT_W'(TIMEOUT - 1));

   // A real conversion arriving on the expiry cycle suppresses the flag.
   always_ff @(posedge clk_clk or negedge reset_n) begin
      if (!reset_n) begin
         timeout <= 1'b0;
      end else if (store_min) begin
         timeout <= 1'b1;
      end else if (clr_flags) begin
         timeout <= 1'b0;
      end
   end
`else
   assign expired = 1'b0;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk_clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         ch    <= '0;
      end else begin
         state <= state_nx;
         ch    <= ch_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      ch_nx      = ch;
      load_frame = 1'b0;
      store_data = 1'b0;
      store_min  = 1'b0;
      accept     = 1'b0;
      nxt        = -1;
      case (state)
         ST_IDLE: begin
            if (tick && ch_mask != '0) begin
               nxt        = next_set_bit(MASK_MAX'(ch_mask), 0);
               ch_nx      = CH_W'(nxt);
               load_frame = 1'b1;
               state_nx   = ST_REQ;
            end
         end
         ST_REQ: begin
            state_nx = ST_WAIT;
         end
         ST_WAIT: begin
            if (conv_done || expired) begin
               store_data = conv_done;
               store_min  = !conv_done;
               nxt        = next_set_bit(MASK_MAX'(mask_q), int'(ch) + 1);
               if (nxt >= 0) begin
                  ch_nx    = CH_W'(nxt);
                  state_nx = ST_REQ;
               end else begin
                  state_nx = ST_PRESENT;
               end
            end
         end
         ST_PRESENT: begin
            if (out_ready) begin
               accept   = 1'b1;
               state_nx = ST_IDLE;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Handshake outputs are flops loaded from the next state so nothing is combinational from inputs.
   always_ff @(posedge clk_clk or negedge reset_n) begin
      if (!reset_n) begin
         mask_q    <= '0;
         slots     <= '0;
         overrun   <= 1'b0;
         frame_cnt <= '0;
         conv_req  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         if (load_frame) begin
            mask_q <= ch_mask;
            slots  <= '0;
         end else if (store_data) begin
            slots[int'(ch)*DATA_W +: DATA_W] <= conv_data;
         end else if (store_min) begin
            slots[int'(ch)*DATA_W +: DATA_W] <= SAMPLE_MIN_W;
         end

         if (tick && state != ST_IDLE) begin
            overrun <= 1'b1;
         end else if (clr_flags) begin
            overrun <= 1'b0;
         end

         if (accept) begin
            frame_cnt <= frame_cnt + 16'd1;
         end

         conv_req  <= (state_nx == ST_REQ);
         out_valid <= (state_nx == ST_PRESENT);
         busy      <= (state_nx != ST_IDLE);
      end
   end

   assign conv_ch  = ch;
   assign out_data = slots;
   assign out_mask = mask_q;

endmodule

// File: tb/tb_adc_frame_sequencer.sv
// Randomized self-checking bench for adc_frame_sequencer with a behavioural ADC
// engine and a frame-level reference model.
module tb_adc_frame_sequencer;

   localparam int NUM_CH   = 4;
   localparam int DATA_W   = 11;
   localparam int RATE_DIV = 32;
   localparam int TIMEOUT  = 8;

   logic                     clk_clk = 1'b0;
   logic                     reset_n;
   logic                     en;
   logic [NUM_CH-1:0]        ch_mask;
   logic                     clr_flags;
   logic                     conv_req;
   logic [1:0]               conv_ch;
   logic                     conv_done;
   logic [DATA_W-1:0]        conv_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [NUM_CH*DATA_W-1:0] out_data;
   logic [NUM_CH-1:0]        out_mask;
   logic                     busy;
   logic                     overrun;
   logic                     timeout;
   logic [15:0]              frame_cnt;

   int                errors = 0;
   int                checks = 0;
   int                cyc = 0;
   int                eng_lat = 3;
   int                withhold_ch = -1;
   int                pend = 0;
   int                pend_ch = 0;
   int                first_req_cyc = 0;
   int                req_log[$];
   logic [DATA_W-1:0] resp [NUM_CH];
   int                exp_frames = 0;
   logic              exp_timeout = 1'b0;

   adc_frame_sequencer #(
      .NUM_CH   (NUM_CH),
      .DATA_W   (DATA_W),
      .RATE_DIV (RATE_DIV),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk_clk   (clk_clk),
      .reset_n   (reset_n),
      .en        (en),
      .ch_mask   (ch_mask),
      .clr_flags (clr_flags),
      .conv_req  (conv_req),
      .conv_ch   (conv_ch),
      .conv_done (conv_done),
      .conv_data (conv_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_mask  (out_mask),
      .busy      (busy),
      .overrun   (overrun),
      .timeout   (timeout),
      .frame_cnt (frame_cnt)
   );

   always #5 clk_clk = ~clk_clk;

   always @(posedge clk_clk) cyc <= cyc + 1;

   // ADC engine model: answers each request L cycles later unless its channel is withheld.
   initial begin
      conv_done = 1'b0;
      conv_data = '0;
      forever begin
         @(negedge clk_clk);
         conv_done = 1'b0;
         if (!reset_n) begin
            pend = 0;
         end else begin
            if (pend > 0) begin
               pend--;
               if (pend == 0) begin
                  conv_done = 1'b1;
                  conv_data = resp[pend_ch];
               end
            end
            if (conv_req) begin
               if (req_log.size() == 0) first_req_cyc = cyc;
               req_log.push_back(int'(conv_ch));
               if (int'(conv_ch) != withhold_ch) begin
                  pend    = eng_lat;
                  pend_ch = int'(conv_ch);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [NUM_CH*DATA_W-1:0] modelFrame(input logic [NUM_CH-1:0] mask, input int withheld);
      logic [NUM_CH*DATA_W-1:0] f;
      logic [DATA_W-1:0]        most_neg;
      most_neg = '0;
      most_neg[DATA_W-1] = 1'b1;
      f = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (mask[i]) f[i*DATA_W +: DATA_W] = (i == withheld) ? most_neg : resp[i];
      end
      return f;
   endfunction

   task automatic randomizeResp();
      for (int i = 0; i < NUM_CH; i++) resp[i] = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
   endtask

   // One full frame: program the mask, let the next tick start it, check and accept it.
   task automatic applyStimulus(input logic [NUM_CH-1:0] mask, input int lat, input int withheld);
      int exp_reqs[$];
      int cycles;
      int valid_cyc;
      bit scrambled;
      for (int i = 0; i < NUM_CH; i++) if (mask[i]) exp_reqs.push_back(i);
      eng_lat     = lat;
      withhold_ch = withheld;
      req_log.delete();
      scrambled = 0;
      @(negedge clk_clk);
      ch_mask = mask;
      cycles  = 0;
      while (!out_valid && cycles < 200) begin
         @(negedge clk_clk);
         cycles++;
         if (req_log.size() > 0 && !scrambled) begin
            ch_mask   = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
            scrambled = 1;
         end
      end
      valid_cyc = cyc;
      checkOutput("frame_present", out_valid, 1'b1);
      checkOutput("out_data", out_data, modelFrame(mask, withheld));
      checkOutput("out_mask", out_mask, mask);
      checkOutput("req_count", req_log.size(), exp_reqs.size());
      for (int i = 0; i < exp_reqs.size() && i < req_log.size(); i++) begin
         checkOutput("req_ch", req_log[i], exp_reqs[i]);
      end
      if (withheld < 0) checkOutput("frame_latency", valid_cyc - first_req_cyc, exp_reqs.size() * (lat + 1));
      checkOutput("overrun_idle", overrun, 1'b0);
      checkOutput("timeout_flag", timeout, exp_timeout);
      out_ready = 1'b1;
      @(negedge clk_clk);
      out_ready = 1'b0;
      exp_frames++;
      checkOutput("valid_drop", out_valid, 1'b0);
      checkOutput("frame_cnt", frame_cnt, exp_frames);
      withhold_ch = -1;
   endtask

   initial begin
      logic [NUM_CH*DATA_W-1:0] snap;
      bit stable;
      int valid_seen;
      int cycles;

      reset_n   = 1'b0;
      en        = 1'b0;
      ch_mask   = '0;
      clr_flags = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < NUM_CH; i++) resp[i] = '0;
      repeat (3) @(negedge clk_clk);
      checkOutput("reset_ctrl", {conv_req, out_valid, busy, overrun, timeout}, 5'b0);
      checkOutput("reset_data", {out_data, out_mask, conv_ch, frame_cnt}, '0);
      reset_n = 1'b1;
      en      = 1'b1;

      $display("[TB] all four channels, fixed data");
      resp[0] = 11'sd100;
      resp[1] = 11'sd200;
      resp[2] = 11'sd300;
      resp[3] = 11'sd400;
      applyStimulus(4'b1111, 3, -1);
      checkOutput("fixed_frame", out_data, {11'sd400, 11'sd300, 11'sd200, 11'sd100});

      $display("[TB] sparse mask 1010");
      randomizeResp();
      applyStimulus(4'b1010, 2, -1);

      $display("[TB] randomized frames");
      for (int n = 0; n < 6; n++) begin
         randomizeResp();
         applyStimulus(NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1)), $urandom_range(1, 5), -1);
      end

`ifdef ADC_SEQ_TIMEOUT_EN
      $display("[TB] withheld conversion on channel 2");
      randomizeResp();
      exp_timeout = 1'b1;
      applyStimulus(4'b1111, 2, 2);
      clr_flags = 1'b1;
      @(negedge clk_clk);
      clr_flags   = 1'b0;
      exp_timeout = 1'b0;
      checkOutput("timeout_clr", timeout, 1'b0);
`endif

      $display("[TB] back-pressure across a tick");
      randomizeResp();
      eng_lat = 2;
      @(negedge clk_clk);
      ch_mask = 4'b1111;
      cycles  = 0;
      while (!out_valid && cycles < 200) begin
         @(negedge clk_clk);
         cycles++;
      end
      checkOutput("bp_present", out_valid, 1'b1);
      checkOutput("bp_data", out_data, modelFrame(4'b1111, -1));
      ch_mask = '0;
      snap    = out_data;
      stable  = 1;
      repeat (40) begin
         @(negedge clk_clk);
         if (out_data !== snap || out_valid !== 1'b1) stable = 0;
      end
      checkOutput("bp_stable", stable, 1'b1);
      checkOutput("bp_overrun", overrun, 1'b1);
      out_ready = 1'b1;
      @(negedge clk_clk);
      out_ready = 1'b0;
      exp_frames++;
      checkOutput("bp_frame_cnt", frame_cnt, exp_frames);
      clr_flags = 1'b1;
      @(negedge clk_clk);
      clr_flags = 1'b0;
      checkOutput("overrun_clr", overrun, 1'b0);

      $display("[TB] empty mask over three ticks");
      req_log.delete();
      valid_seen = 0;
      repeat (3 * RATE_DIV + 4) begin
         @(negedge clk_clk);
         if (out_valid) valid_seen++;
      end
      checkOutput("empty_reqs", req_log.size(), 0);
      checkOutput("empty_valid", valid_seen, 0);
      checkOutput("empty_overrun", overrun, 1'b0);

      $display("[TB] reset during WAIT");
      randomizeResp();
      eng_lat = 5;
      req_log.delete();
      @(negedge clk_clk);
      ch_mask = 4'b1111;
      cycles  = 0;
      while (req_log.size() == 0 && cycles < 200) begin
         @(negedge clk_clk);
         cycles++;
      end
      checkOutput("pre_reset_req", req_log.size() > 0, 1'b1);
      repeat (2) @(negedge clk_clk);
      checkOutput("pre_reset_busy", busy, 1'b1);
      reset_n = 1'b0;
      #1;
      exp_frames = 0;
      checkOutput("abort_ctrl", {conv_req, out_valid, busy, overrun, timeout}, 5'b0);
      checkOutput("abort_data", {out_data, out_mask, conv_ch}, '0);
      checkOutput("abort_frame_cnt", frame_cnt, 16'd0);
      @(negedge clk_clk);
      reset_n = 1'b1;
      randomizeResp();
      applyStimulus(4'b1111, 2, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
